// File: rtl/branch_resolve_ex.sv
// ID/EX pipeline register with execute-stage branch/JAL/JALR resolution.
// Drives the fetch redirect, squashes its own wrong-path capture, and keeps branch statistics.
module branch_resolve_ex #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallE,
  input  logic                 flushE,
  input  logic                 validD,
  input  logic                 branchD,
  input  logic                 jumpD,
  input  logic                 jalrD,
  input  logic [2:0]           funct3D,
  input  logic [WIDTH-1:0]     rd1D,
  input  logic [WIDTH-1:0]     rd2D,
  input  logic [WIDTH-1:0]     immD,
  input  logic [WIDTH-1:0]     pcD,
  input  logic [WIDTH-1:0]     pcplus4D,
  output logic                 pcsrcE,
  output logic [WIDTH-1:0]     pctargetE,
  output logic [WIDTH-1:0]     linkE,
  output logic                 validE,
  output logic                 misalignE,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  logic                 valid_q, valid_d;
  logic                 branch_q, branch_d;
  logic                 jump_q, jump_d;
  logic                 jalr_q, jalr_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [WIDTH-1:0]     rd1_q, rd1_d;
  logic [WIDTH-1:0]     rd2_q, rd2_d;
  logic [WIDTH-1:0]     imm_q, imm_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     pcplus4_q, pcplus4_d;
  logic                 misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  logic                 cond_c;
  logic                 pcsrc_c;
  logic [WIDTH-1:0]     jalr_sum_c;
  logic [WIDTH-1:0]     target_c;

  // Branch condition evaluated on the EX operands
  always_comb begin
    cond_c = 1'b0;
    case (funct3_q)
      3'b000:  cond_c = (rd1_q == rd2_q);
      3'b001:  cond_c = (rd1_q != rd2_q);
      3'b100:  cond_c = ($signed(rd1_q) <  $signed(rd2_q));
      3'b101:  cond_c = ($signed(rd1_q) >= $signed(rd2_q));
      3'b110:  cond_c = (rd1_q <  rd2_q);
      3'b111:  cond_c = (rd1_q >= rd2_q);
      default: cond_c = 1'b0;
    endcase
  end

  // Redirect decision and target; JALR takes precedence over a branch flag
  always_comb begin
    jalr_sum_c = rd1_q + imm_q;
    target_c   = jalr_q ? {jalr_sum_c[WIDTH-1:1], 1'b0} : (pc_q + imm_q);
    pcsrc_c    = valid_q & (jump_q | jalr_q | (branch_q & cond_c));
  end

  // Next-state: hold on stall, bubble on flush/redirect/invalid decode, else capture
  always_comb begin
    valid_d      = valid_q;
    branch_d     = branch_q;
    jump_d       = jump_q;
    jalr_d       = jalr_q;
    funct3_d     = funct3_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    pcplus4_d    = pcplus4_q;
    misalign_d   = misalign_q | (pcsrc_c & target_c[1]);
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;

    if (!stallE) begin
      if (flushE || pcsrc_c || !validD) begin
        valid_d   = 1'b0;
        branch_d  = 1'b0;
        jump_d    = 1'b0;
        jalr_d    = 1'b0;
        funct3_d  = 3'b000;
        rd1_d     = '0;
        rd2_d     = '0;
        imm_d     = '0;
        pc_d      = '0;
        pcplus4_d = '0;
      end else begin
        valid_d   = 1'b1;
        branch_d  = branchD;
        jump_d    = jumpD;
        jalr_d    = jalrD;
        funct3_d  = funct3D;
        rd1_d     = rd1D;
        rd2_d     = rd2D;
        imm_d     = immD;
        pc_d      = pcD;
        pcplus4_d = pcplus4D;
      end

      // Statistics count each instruction once as it leaves EX, saturating at all-ones
      if (valid_q) begin
        if (branch_q && (branch_cnt_q != {CNT_WIDTH{1'b1}})) begin
          branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (pcsrc_c && (taken_cnt_q != {CNT_WIDTH{1'b1}})) begin
          taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      jalr_q       <= 1'b0;
      funct3_q     <= 3'b000;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      pcplus4_q    <= '0;
      misalign_q   <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      jalr_q       <= jalr_d;
      funct3_q     <= funct3_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      pcplus4_q    <= pcplus4_d;
      misalign_q   <= misalign_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign pcsrcE     = pcsrc_c;
  assign pctargetE  = target_c;
  assign linkE      = pcplus4_q;
  assign validE     = valid_q;
  assign misalignE  = misalign_q;
  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ex.sv
// Bench for branch_resolve_ex: directed scenarios plus random traffic against an
// instruction-level reference model; a second instance uses 4-bit counters for saturation.
module tb_branch_resolve_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallE, flushE, validD, branchD, jumpD, jalrD;
  logic [2:0]  funct3D;
  logic [31:0] rd1D, rd2D, immD, pcD, pcplus4D;

  logic        pcsrcE, validE, misalignE;
  logic [31:0] pctargetE, linkE;
  logic [15:0] branch_cnt, taken_cnt;

  logic        s_pcsrcE, s_validE, s_misalignE;
  logic [31:0] s_pctargetE, s_linkE;
  logic [3:0]  s_branch_cnt, s_taken_cnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_ex dut (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .validD(validD),
    .branchD(branchD), .jumpD(jumpD), .jalrD(jalrD), .funct3D(funct3D),
    .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .pcD(pcD), .pcplus4D(pcplus4D),
    .pcsrcE(pcsrcE), .pctargetE(pctargetE), .linkE(linkE), .validE(validE),
    .misalignE(misalignE), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve_ex #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .validD(validD),
    .branchD(branchD), .jumpD(jumpD), .jalrD(jalrD), .funct3D(funct3D),
    .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .pcD(pcD), .pcplus4D(pcplus4D),
    .pcsrcE(s_pcsrcE), .pctargetE(s_pctargetE), .linkE(s_linkE), .validE(s_validE),
    .misalignE(s_misalignE), .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction occupying EX plus retirement tallies
  typedef struct packed {
    logic        valid, branch, jump, jalr;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, imm, pc, pc4;
  } ex_t;

  ex_t m_e;
  int  m_bcnt, m_tcnt;
  bit  m_mis;

  function automatic bit m_taken(input ex_t e);
    bit c;
    case (e.f3)
      3'd0:    c = (e.rd1 == e.rd2);
      3'd1:    c = (e.rd1 != e.rd2);
      3'd4:    c = (int'(e.rd1) <  int'(e.rd2));
      3'd5:    c = (int'(e.rd1) >= int'(e.rd2));
      3'd6:    c = (longint'({32'h0, e.rd1}) <  longint'({32'h0, e.rd2}));
      3'd7:    c = (longint'({32'h0, e.rd1}) >= longint'({32'h0, e.rd2}));
      default: c = 1'b0;
    endcase
    return e.valid && (e.jump || e.jalr || (e.branch && c));
  endfunction

  function automatic logic [31:0] m_target(input ex_t e);
    logic [31:0] t;
    if (e.jalr) t = (e.rd1 + e.imm) & 32'hFFFF_FFFE;
    else        t = e.pc + e.imm;
    return t;
  endfunction

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " validE"},     64'(validE),     64'(m_e.valid));
    chk({tag, " pcsrcE"},     64'(pcsrcE),     64'(m_taken(m_e)));
    chk({tag, " pctargetE"},  64'(pctargetE),  64'(m_target(m_e)));
    chk({tag, " linkE"},      64'(linkE),      64'(m_e.pc4));
    chk({tag, " misalignE"},  64'(misalignE),  64'(m_mis));
    chk({tag, " branch_cnt"}, 64'(branch_cnt), 64'(sat(m_bcnt, 65535)));
    chk({tag, " taken_cnt"},  64'(taken_cnt),  64'(sat(m_tcnt, 65535)));
    chk({tag, " sat branch"}, 64'(s_branch_cnt), 64'(sat(m_bcnt, 15)));
    chk({tag, " sat taken"},  64'(s_taken_cnt),  64'(sat(m_tcnt, 15)));
    chk({tag, " sat pcsrc"},  64'(s_pcsrcE),     64'(m_taken(m_e)));
  endtask

  task automatic model_reset();
    m_e    = '0;
    m_bcnt = 0;
    m_tcnt = 0;
    m_mis  = 1'b0;
  endtask

  task automatic model_edge();
    bit          tk = m_taken(m_e);
    logic [31:0] tg = m_target(m_e);
    if (tk && tg[1]) m_mis = 1'b1;
    if (!stallE) begin
      if (m_e.valid) begin
        if (m_e.branch) m_bcnt++;
        if (tk) m_tcnt++;
      end
      if (flushE || tk || !validD) m_e = '0;
      else m_e = {1'b1, branchD, jumpD, jalrD, funct3D, rd1D, rd2D, immD, pcD, pcplus4D};
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic j, input logic jr,
                       input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [31:0] pc);
    validD = v; branchD = b; jumpD = j; jalrD = jr; funct3D = f3;
    rd1D = r1; rd2D = r2; immD = imm; pcD = pc; pcplus4D = pc + 32'd4;
  endtask

  task automatic tick(input logic st, input logic fl, input string tag);
    stallE = st;
    flushE = fl;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [2:0] SIGNED_F3 [5] = '{3'd4, 3'd6, 3'd7, 3'd5, 3'd2};
  localparam bit         SIGNED_TK [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [2:0] f3;
    rst = 1'b0; stallE = 1'b0; flushE = 1'b0;
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // BEQ taken: redirect to 0x120, then a squashed slot
    drive(1, 1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100);
    tick(0, 0, "beq");
    chk("beq pcsrc", 64'(pcsrcE), 64'd1);
    chk("beq target", 64'(pctargetE), 64'h120);
    drive(1, 0, 0, 0, 3'd0, 32'd1, 32'd2, 32'd0, 32'h104);
    tick(0, 0, "beq squash");
    chk("beq squash valid", 64'(validE), 64'd0);
    chk("beq bcnt", 64'(branch_cnt), 64'd1);
    chk("beq tcnt", 64'(taken_cnt), 64'd1);

    // Signed vs unsigned compares with -1 against 1
    for (int i = 0; i < 5; i++) begin
      f3 = SIGNED_F3[i];
      drive(1, 1, 0, 0, f3, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200);
      tick(0, 0, "sgn");
      chk($sformatf("sgn f3=%0d", f3), 64'(pcsrcE), 64'(SIGNED_TK[i]));
      drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
      tick(0, 0, "sgn drain");
    end

    // JALR with odd target bit 1: sticky misalign
    drive(1, 0, 0, 1, 3'd0, 32'h1003, 32'd0, 32'h4, 32'h300);
    tick(0, 0, "jalr");
    chk("jalr target", 64'(pctargetE), 64'h1006);
    chk("jalr link", 64'(linkE), 64'h304);
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    tick(0, 0, "jalr drain");
    chk("jalr misalign", 64'(misalignE), 64'd1);
    drive(1, 1, 0, 0, 3'd1, 32'd1, 32'd2, 32'h10, 32'h400);
    tick(0, 0, "bne after jalr");
    tick(0, 0, "bne drain");
    chk("misalign sticky", 64'(misalignE), 64'd1);

    // Taken branch held by stall for 3 cycles, then released
    drive(1, 1, 0, 0, 3'd0, 32'd7, 32'd7, 32'h8, 32'h500);
    tick(0, 0, "stall load");
    drive(1, 0, 1, 0, 3'd0, 0, 0, 32'h100, 32'h504);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, "stall");
      chk("stall pcsrc", 64'(pcsrcE), 64'd1);
      chk("stall target", 64'(pctargetE), 64'h508);
    end
    tick(0, 0, "stall release");
    chk("release bubble", 64'(validE), 64'd0);

    // Flush over a valid non-branch: E cleared, counters untouched
    drive(1, 0, 0, 0, 3'd0, 32'd3, 32'd3, 32'd0, 32'h600);
    tick(0, 0, "alu");
    drive(1, 1, 0, 0, 3'd0, 32'd3, 32'd3, 32'h10, 32'h604);
    tick(0, 1, "flush");
    chk("flush valid", 64'(validE), 64'd0);

    // Target wrap-around
    drive(1, 0, 1, 0, 3'd0, 0, 0, 32'h20, 32'hFFFF_FFF0);
    tick(0, 0, "wrap");
    chk("wrap target", 64'(pctargetE), 64'h10);
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    tick(0, 0, "wrap drain");

    // 20 taken jumps saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 3'd0, 0, 0, 32'h40, 32'(32'h800 + 8 * i));
      tick(0, 0, "jal");
      drive(1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
      tick(0, 0, "jal squash");
    end
    chk("sat taken 0xF", 64'(s_taken_cnt), 64'hF);

    // Reset asserted mid-stall with a taken BEQ in EX
    drive(1, 1, 0, 0, 3'd0, 32'd9, 32'd9, 32'h20, 32'h900);
    tick(0, 0, "pre reset");
    tick(1, 0, "pre reset stall");
    do_reset("mid reset");
    chk("mid reset pcsrc", 64'(pcsrcE), 64'd0);
    chk("mid reset tcnt", 64'(taken_cnt), 64'd0);
    drive(1, 1, 0, 0, 3'd0, 32'd1, 32'd1, 32'h30, 32'hA00);
    tick(0, 0, "post reset");
    chk("post reset target", 64'(pctargetE), 64'hA30);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom());
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 7) == 0),
            3'($urandom_range(0, 7)), a, b, 32'($urandom()), 32'($urandom()));
      tick(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 9) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/branch_resolve_ex.md
Name: branch_resolve_ex

Overview:
- ID/EX pipeline register plus execute-stage control-flow resolution for the pipelined RV32I core.
- Captures the decoded instruction from the decode stage and evaluates branch, JAL and JALR.
- Drives pcsrcE/pctargetE back to fetch, the redirect end of the fetch interface.
- Squashes its own wrong-path capture on redirect; keeps saturating branch statistics.

Parameters:
WIDTH, 32, datapath / address width
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
stallE  input  1  hold the ID/EX register contents
flushE  input  1  load a bubble into ID/EX (hazard unit)
validD  input  1  decode slot holds a real instruction
branchD  input  1  conditional branch
jumpD  input  1  JAL
jalrD  input  1  JALR
funct3D  input  3  branch condition
rd1D  input  WIDTH  rs1 value
rd2D  input  WIDTH  rs2 value
immD  input  WIDTH  sign-extended immediate
pcD  input  WIDTH  instruction PC
pcplus4D  input  WIDTH  PC+4
pcsrcE  output  1  redirect fetch this cycle
pctargetE  output  WIDTH  redirect address
linkE  output  WIDTH  pcplus4E, link value for JAL/JALR
validE  output  1  EX slot valid
misalignE  output  1  sticky: a taken target had bit 1 set
branch_cnt  output  CNT_WIDTH  retired conditional branches
taken_cnt  output  CNT_WIDTH  retired taken branches/jumps

Behaviour:
- rst low: asynchronous clear of all registers.
  - validE, pcsrcE, misalignE, counters and all E fields are 0; pctargetE = 0.
- Register update at posedge clk, priority:
  1. stallE = 1: hold every E field.
  2. flushE = 1 or pcsrcE = 1: bubble; all E fields and validE are 0.
  3. Otherwise capture the D inputs.
- The pcsrcE squash removes the wrong-path instruction sitting in decode.
  - Fetch already squashes IF/ID on pcsrcE, so a taken branch costs exactly 2 bubbles.
- Branch condition on rd1E/rd2E by funct3E:
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010, 011: never taken.
- pcsrcE = validE & (jumpE | jalrE | (branchE & cond)); combinational from E registers, zero latency.
- If jalrE and branchE are both set, jalrE wins.
- pctargetE:
  - jalrE: (rd1E + immE) with bit 0 cleared.
  - Otherwise: pcE + immE.
  - Modulo 2^WIDTH; wrap-around is silent.
- pctargetE is driven every cycle; it is meaningful only when pcsrcE = 1.
- misalignE is set on any cycle with pcsrcE = 1 and pctargetE[1] = 1.
  - It is sticky until reset.
  - The redirect still occurs.
- While stallE holds a taken branch, pcsrcE stays high every stalled cycle; fetch redirects repeatedly to the same target (idempotent).
  - The squash happens on the first non-stalled edge.
- Counters update on an edge where validE = 1 and stallE = 0 (instruction leaving EX), so each instruction counts once.
  - branch_cnt increments if branchE.
  - taken_cnt increments if pcsrcE.
  - Both saturate at all-ones; no wrap.
- validD = 0 captures as a bubble: validE = 0, so pcsrcE and counters are inert.
- Reset mid-stall or mid-redirect: immediate clear; the first post-reset edge captures normally.

Test Plan:
- Reset: rst low mid-operation with E holding a taken BEQ -> pcsrcE, validE, counters and misalignE drop to 0 immediately, without waiting for a clock edge.
- BEQ taken: pcD=0x100, immD=0x20, rd1D=rd2D=5, funct3=000 -> next cycle pcsrcE=1, pctargetE=0x120; the following cycle validE=0; branch_cnt=1, taken_cnt=1.
- Signed vs unsigned: rd1=0xFFFFFFFF, rd2=1 -> BLT taken, BLTU not taken, BGEU taken, BGE not taken; funct3=010 never taken.
- JALR: rd1=0x1003, imm=0x4 -> pctargetE=0x1006, misalignE=1 and remains 1 after later normal branches; linkE=pcplus4 of the JALR.
- Stall/flush priority: taken branch in E with stallE=1 for 3 cycles -> pcsrcE high all 3 cycles, counters unchanged, E held; on release, one increment and an E bubble. With flushE=1 and stallE=0, E is cleared and no counter changes.
- Saturation/wrap: preload via 2^CNT_WIDTH taken jumps (CNT_WIDTH=4 build, 20 jumps) -> taken_cnt sticks at 0xF. pcD=0xFFFFFFF0, imm=0x20 -> pctargetE=0x00000010.
